sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single 32-bit asynchronous base SRAM between the CPU instruction-fetch port and data-memory port. Each access is sequenced through a small state machine that generates SRAM strobes with fixed setup, pulse and hold phases and captures read data into a register. The block returns a one-cycle acknowledge per port, which the CPU uses to release its pipeline stall. It sits between the openmips core and the base_ram pins in thinpad_top and replaces the direct strobe assignments there.

## Interface
- WAIT_CYCLES, 1: extra SRAM access cycles. Range 0–7. Read phase and write pulse each last WAIT_CYCLES+1 cycles.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request. Held until if_ack_o.
- if_addr_i  in  32  fetch byte address.
- if_data_o  out  32  fetch data. Valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle fetch completion.
- mem_req_i  in  1  data request. Held until mem_ack_o.
- mem_we_i  in  1  1=write, 0=read.
- mem_addr_i  in  32  data byte address.
- mem_sel_i  in  4  byte enables, active-high.
- mem_data_i  in  32  write data.
- mem_data_o  out  32  read data. Valid while mem_ack_o=1.
- mem_ack_o  out  1  one-cycle data completion.
- sram_addr_o  out  20  SRAM word address = granted addr[21:2].
- sram_data_io  inout  32  SRAM data bus.
- sram_be_n_o  out  4  byte enables, active-low.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM strobes, active-low.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, DONE. There is a 3-bit phase counter `cnt`.
- IDLE: strobes high, bus Z. On a clock edge with any request pending:
  - register grant, address, sel (reads force be_n=0000) and write data;
  - a read goes to RD and a write goes to WR_SETUP, with cnt=WAIT_CYCLES.
- Arbitration: if both requests are pending at the same edge, the MEM port wins (fixed priority). Fetches are always reads, and if_* ignores we/sel.
- RD: ce_n=0, oe_n=0, we_n=1, bus Z.
  - cnt decrements each edge.
  - At the edge where cnt==0, sram_data_io is captured into rdata and the state goes to DONE.
- WR_SETUP: ce_n=0, oe_n=1, we_n=1, bus driven with the write data. Lasts 1 cycle, then goes to WR_PULSE with cnt=WAIT_CYCLES.
- WR_PULSE: we_n=0 and the bus stays driven. cnt decrements each edge; when cnt==0 the state goes to DONE.
- DONE: we_n=1 and oe_n=1.
  - ce_n=0 and the bus stays driven on writes, giving a hold phase.
  - The granted port's ack=1 and its data_o=rdata. Writes return undefined data.
  - Next state is IDLE.
- The bus is driven only in WR_SETUP, WR_PULSE and DONE of a write, and is Z otherwise.
- A requester either drops req or presents its next request at the edge where its ack is 1. The arbiter does not look at requests while in DONE.
- Request deasserted mid-access is illegal. The access still completes and the ack is still issued.

## Timing
- Reset values: sram_ce_n_o, sram_oe_n_o, sram_we_n_o = 1; sram_be_n_o=1111; sram_addr_o=0; bus Z; both acks 0; if_data_o and mem_data_o = 0; state IDLE.
- Asserting reset mid-access forces the reset values immediately (asynchronous). No ack is issued for the aborted access.
- Read latency: the request is sampled at edge E0 and the ack is high during cycle E0+WAIT_CYCLES+1 … +1 cycle. With WAIT_CYCLES=1, the ack occupies the 3rd cycle after E0.
- Write latency: the ack is high WAIT_CYCLES+3 cycles after E0. With WAIT_CYCLES=1, the ack is in the 4th cycle.
- Minimum request spacing is one IDLE cycle. Read throughput is 1 access per WAIT_CYCLES+3 cycles.
- All SRAM outputs are registered; sram_we_n_o is glitch-free.
- The address is stable from the first strobe to the end of DONE.

## Configuration
- SRAM_ARB_RR_EN:
  - Defined: round-robin. A 1-bit `last` register is set on each grant. On a simultaneous request, the port not granted last wins. Reset value of `last` is IF, so MEM wins the first tie.
  - Undefined: fixed MEM priority. A continuous MEM stream may starve IF.

## Test plan
- Fetch read, WAIT_CYCLES=1: SRAM model holds 0xDEADBEEF at word 0x00010, and the bench sets if_addr_i=0x40. Required: sram_addr_o=0x00010 and oe_n=0 for 2 cycles; if_ack_o=1 for exactly 1 cycle, in the 3rd cycle after the request edge, with if_data_o=0xDEADBEEF.
- Byte write: mem_we_i=1, sel=0010, data=0x0000AB00, address 0x8. Required: be_n=1101; we_n low for 2 cycles, bounded by one setup and one hold cycle with the bus driven; word 2 byte1=0xAB, other bytes unchanged; mem_ack_o in the 4th cycle.
- Simultaneous IF and MEM read requests:
  - with the macro undefined, mem_ack_o precedes if_ack_o;
  - with SRAM_ARB_RR_EN defined, back-to-back ties alternate MEM, IF, MEM, IF.
- Bus contention check: over 1000 random accesses, assert sram_data_io is never driven while sram_oe_n_o=0. A write followed by a read to the same address returns the written value.
- Reset mid-write: drive rst=0 while in WR_PULSE. Required: we_n=1 and bus Z in the same cycle with no clock edge needed; no ack. After release, state IDLE and the next read is serviced normally.
- WAIT_CYCLES=0 and WAIT_CYCLES=7: read ack at the 2nd and 9th cycles respectively; write ack at the 3rd and 10th cycles.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// CPU-side handshake bundle for sram_arbiter: instruction-fetch port and data port.
interface sram_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ack_o;

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  if_data_o, if_ack_o, mem_data_o, mem_ack_o
    );
    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output if_data_o, if_ack_o, mem_data_o, mem_ack_o
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one async 32-bit SRAM between the fetch and data ports with fixed setup/pulse/hold strobes.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed MEM priority.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus,
    output logic [19:0]   sram_addr_o,
    inout  wire  [31:0]   sram_data_io,
    output logic [3:0]    sram_be_n_o,
    output logic          sram_ce_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_we_n_o
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, DONE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        gnt_mem, gnt_mem_nxt;
    logic        wr, wr_nxt;
    logic        pick_mem, ld;
    logic [31:0] wdata, rdata;
    logic        drv;
    logic        if_ack_q, mem_ack_q;
    logic        ce_n_nxt, oe_n_nxt, we_n_nxt, drv_nxt, if_ack_nxt, mem_ack_nxt;

`ifdef SRAM_ARB_RR_EN
    logic last;  // 1 = MEM was granted last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    last <= 1'b0;
        else if (ld) last <= pick_mem;
    end
    always_comb pick_mem = bus.mem_req_i && (!bus.if_req_i || !last);
`else
    always_comb pick_mem = bus.mem_req_i;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gnt_mem_nxt = gnt_mem;
        wr_nxt      = wr;
        ld          = 1'b0;
        case (state)
            IDLE: if (bus.mem_req_i || bus.if_req_i) begin
                ld          = 1'b1;
                gnt_mem_nxt = pick_mem;
                wr_nxt      = pick_mem && bus.mem_we_i;
                state_nxt   = wr_nxt ? WR_SETUP : RD;
                cnt_nxt     = CNT_INIT;
            end
            RD, WR_PULSE: begin
                if (cnt == 3'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 3'd1;
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = CNT_INIT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the next state and registered, so pins never glitch.
        ce_n_nxt    = !((state_nxt == RD) || (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                        ((state_nxt == DONE) && wr_nxt));
        oe_n_nxt    = (state_nxt != RD);
        we_n_nxt    = (state_nxt != WR_PULSE);
        drv_nxt     = wr_nxt && ((state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) || (state_nxt == DONE));
        if_ack_nxt  = (state_nxt == DONE) && !gnt_mem_nxt;
        mem_ack_nxt = (state_nxt == DONE) && gnt_mem_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            gnt_mem     <= 1'b0;
            wr          <= 1'b0;
            wdata       <= '0;
            rdata       <= '0;
            drv         <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            sram_addr_o <= '0;
            sram_be_n_o <= 4'hF;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            gnt_mem     <= gnt_mem_nxt;
            wr          <= wr_nxt;
            drv         <= drv_nxt;
            if_ack_q    <= if_ack_nxt;
            mem_ack_q   <= mem_ack_nxt;
            sram_ce_n_o <= ce_n_nxt;
            sram_oe_n_o <= oe_n_nxt;
            sram_we_n_o <= we_n_nxt;
            if (ld) begin
                sram_addr_o <= pick_mem ? bus.mem_addr_i[21:2] : bus.if_addr_i[21:2];
                sram_be_n_o <= (pick_mem && bus.mem_we_i) ? ~bus.mem_sel_i : 4'h0;
                wdata       <= bus.mem_data_i;
            end
            if ((state == RD) && (cnt == 3'd0)) rdata <= sram_data_io;
        end
    end

    assign sram_data_io  = drv ? wdata : 32'bz;
    assign bus.if_ack_o  = if_ack_q;
    assign bus.mem_ack_o = mem_ack_q;
    assign bus.if_data_o = rdata;
    assign bus.mem_data_o = rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, scoreboard, tie/stream, reset-abort and latency corners.
`timescale 1ns/1ps
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  sram_arbiter_if b1();
  sram_arbiter_if b0();
  sram_arbiter_if b7();

  wire [31:0] d1, d0, d7;
  logic [19:0] a1, a0, a7;
  logic [3:0]  be1, be0, be7;
  logic ce1, oe1, we1, ce0, oe0, we0, ce7, oe7, we7;

  sram_arbiter #(.WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1), .sram_addr_o(a1), .sram_data_io(d1),
    .sram_be_n_o(be1), .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(we1));
  sram_arbiter #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0), .sram_addr_o(a0), .sram_data_io(d0),
    .sram_be_n_o(be0), .sram_ce_n_o(ce0), .sram_oe_n_o(oe0), .sram_we_n_o(we0));
  sram_arbiter #(.WAIT_CYCLES(7)) u7 (.clk(clk), .rst(rst), .bus(b7), .sram_addr_o(a7), .sram_data_io(d7),
    .sram_be_n_o(be7), .sram_ce_n_o(ce7), .sram_oe_n_o(oe7), .sram_we_n_o(we7));

  // Async SRAM model for the main instance: reads while ce/oe low, writes latch on the rising we_n edge.
  logic [31:0] sram   [0:1023];
  logic [31:0] shadow [0:1023];
  logic [31:0] sb_q[$];

  assign d1 = (!ce1 && !oe1) ? sram[a1[9:0]] : 32'bz;
  assign d0 = !oe0 ? 32'hC0DE0000 : 32'bz;
  assign d7 = !oe7 ? 32'h7777AAAA : 32'bz;

  always @(posedge we1) begin
    if (rst && !ce1)
      for (int k = 0; k < 4; k++)
        if (!be1[k]) sram[a1[9:0]][8*k +: 8] = d1[8*k +: 8];
  end

  always @(negedge clk) begin
    if (rst) begin
      if (!oe1 && !we1) viol++;
      if (!oe1 && ce1)  viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  task automatic do_access(input bit pm, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, output int lat, output int oe_c, output int we_c,
                           output int ce_c, output logic [3:0] be_s, output logic [19:0] a_s,
                           output logic [31:0] rd, output bit one);
    lat = -1; oe_c = 0; we_c = 0; ce_c = 0; be_s = 4'hF; a_s = '0; rd = '0; one = 1'b0;
    if (pm) begin
      b1.mem_req_i = 1'b1; b1.mem_we_i = we; b1.mem_addr_i = addr; b1.mem_sel_i = sel; b1.mem_data_i = wd;
    end else begin
      b1.if_req_i = 1'b1; b1.if_addr_i = addr;
    end
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (!oe1) oe_c++;
      if (!we1) we_c++;
      if (!ce1) ce_c++;
      if (!oe1 || !we1) begin be_s = be1; a_s = a1; end
      if (pm ? b1.mem_ack_o : b1.if_ack_o) begin
        lat = k;
        rd = pm ? b1.mem_data_o : b1.if_data_o;
        b1.mem_req_i = 1'b0; b1.if_req_i = 1'b0;
        @(posedge clk); #1;
        one = !(b1.mem_ack_o || b1.if_ack_o);
        break;
      end
    end
    b1.mem_req_i = 1'b0; b1.if_req_i = 1'b0;
  endtask

  // One access on the WAIT_CYCLES=1 instance, with expected data taken from the shadow memory.
  task automatic xfer(input string tag, input bit pm, input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] wd, input int exp_lat, input logic [3:0] exp_be);
    int lat, oe_c, we_c, ce_c;
    logic [3:0] be_s;
    logic [19:0] a_s;
    logic [31:0] rd, exp_d;
    bit one;
    if (we) shadow[addr[11:2]] = merge(shadow[addr[11:2]], wd, sel);
    else    sb_q.push_back(shadow[addr[11:2]]);
    do_access(pm, we, addr, sel, wd, lat, oe_c, we_c, ce_c, be_s, a_s, rd, one);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_be_n"}, 32'(be_s), 32'(exp_be));
    chk({tag, "_addr"}, 32'(a_s), 32'(addr[21:2]));
    chk({tag, "_ack_1cyc"}, 32'(one), 32'd1);
    if (we) begin
      chk({tag, "_we_cycles"}, oe_c == 0 ? we_c : -1, 2);
      chk({tag, "_ce_cycles"}, ce_c, 4);
    end else begin
      chk({tag, "_oe_cycles"}, oe_c, 2);
      exp_d = sb_q.pop_front();
      chk({tag, "_data"}, rd, exp_d);
    end
  endtask

  task automatic probe(input bit w7, input bit we, output int lat, output logic [31:0] rd);
    logic ack;
    lat = -1; rd = '0;
    if (w7) begin b7.mem_req_i = 1'b1; b7.mem_we_i = we; b7.mem_addr_i = 32'h10; b7.mem_sel_i = 4'hF; end
    else    begin b0.mem_req_i = 1'b1; b0.mem_we_i = we; b0.mem_addr_i = 32'h10; b0.mem_sel_i = 4'hF; end
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      ack = w7 ? b7.mem_ack_o : b0.mem_ack_o;
      if (ack) begin
        lat = k;
        rd = w7 ? b7.mem_data_o : b0.mem_data_o;
        break;
      end
    end
    b0.mem_req_i = 1'b0; b7.mem_req_i = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit pm; bit we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wd; int lat; logic [3:0] be;
  } vec_t;
  vec_t vt[8];

`ifdef SRAM_ARB_RR_EN
  localparam logic [3:0] EXP_ORD = 4'b0101;
`else
  localparam logic [3:0] EXP_ORD = 4'b1111;
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [31:0] rd, a;
    logic [3:0] ord, s;
    bit got;

    for (int i = 0; i < 1024; i++) begin
      sram[i] = (i * 32'h01030507) ^ 32'hA5000000;
      shadow[i] = (i * 32'h01030507) ^ 32'hA5000000;
    end
    sram[16] = 32'hDEADBEEF;
    shadow[16] = 32'hDEADBEEF;

    b1.if_req_i = 0; b1.if_addr_i = 0; b1.mem_req_i = 0; b1.mem_we_i = 0; b1.mem_addr_i = 0; b1.mem_sel_i = 0; b1.mem_data_i = 0;
    b0.if_req_i = 0; b0.if_addr_i = 0; b0.mem_req_i = 0; b0.mem_we_i = 0; b0.mem_addr_i = 0; b0.mem_sel_i = 0; b0.mem_data_i = 32'h1;
    b7.if_req_i = 0; b7.if_addr_i = 0; b7.mem_req_i = 0; b7.mem_we_i = 0; b7.mem_addr_i = 0; b7.mem_sel_i = 0; b7.mem_data_i = 32'h1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {29'd0, ce1, oe1, we1}, 32'd7);
    chk("rst_be_n", 32'(be1), 32'hF);
    chk("rst_addr", 32'(a1), 32'd0);
    chk("rst_acks", {30'd0, b1.if_ack_o, b1.mem_ack_o}, 32'd0);
    chk("rst_data", b1.if_data_o | b1.mem_data_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Both ports requesting continuously from reset: arbitration order of the first four grants
    b1.if_req_i = 1'b1; b1.if_addr_i = 32'h40;
    b1.mem_req_i = 1'b1; b1.mem_we_i = 1'b0; b1.mem_addr_i = 32'h8; b1.mem_sel_i = 4'h0;
    n = 0; ord = '0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(posedge clk); #1;
      if (b1.mem_ack_o) begin ord[n] = 1'b1; n++; chk("tie_mem_data", b1.mem_data_o, shadow[2]); end
      else if (b1.if_ack_o) begin ord[n] = 1'b0; n++; chk("tie_if_data", b1.if_data_o, shadow[16]); end
    end
    b1.mem_req_i = 1'b0;
    chk("tie_grants", n, 4);
    chk("tie_order", 32'(ord), 32'(EXP_ORD));
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (b1.if_ack_o) begin got = 1'b1; chk("tie_if_late_data", b1.if_data_o, 32'hDEADBEEF); break; end
    end
    b1.if_req_i = 1'b0;
    chk("tie_if_served", 32'(got), 32'd1);
    @(posedge clk); #1;

    // Vector table on the WAIT_CYCLES=1 instance
    vt[0] = '{0, 0, 32'h0000_0040, 4'h0, 32'h0,          3, 4'h0};
    vt[1] = '{1, 1, 32'h0000_0008, 4'h2, 32'h0000_AB00,  4, 4'hD};
    vt[2] = '{1, 0, 32'h0000_0008, 4'h0, 32'h0,          3, 4'h0};
    vt[3] = '{1, 1, 32'h0000_0100, 4'hF, 32'h1234_5678,  4, 4'h0};
    vt[4] = '{0, 0, 32'h0000_0100, 4'h0, 32'h0,          3, 4'h0};
    vt[5] = '{1, 1, 32'h0000_0104, 4'h9, 32'hA1B2_C3D4,  4, 4'h6};
    vt[6] = '{1, 0, 32'h0000_0104, 4'h0, 32'h0,          3, 4'h0};
    vt[7] = '{0, 0, 32'hFFC0_0008, 4'h0, 32'h0,          3, 4'h0};
    for (int i = 0; i < 8; i++)
      xfer($sformatf("vec%0d", i), vt[i].pm, vt[i].we, vt[i].addr, vt[i].sel, vt[i].wd, vt[i].lat, vt[i].be);
    chk("byte_write_word2", sram[2], (((32'd2 * 32'h01030507) ^ 32'hA5000000) & 32'hFFFF00FF) | 32'h0000AB00);

    // Latency at the WAIT_CYCLES extremes
    probe(1'b0, 1'b0, lat, rd);
    chk("w0_read_lat", lat, 2);
    chk("w0_read_data", rd, 32'hC0DE0000);
    probe(1'b0, 1'b1, lat, rd);
    chk("w0_write_lat", lat, 3);
    probe(1'b1, 1'b0, lat, rd);
    chk("w7_read_lat", lat, 9);
    chk("w7_read_data", rd, 32'h7777AAAA);
    probe(1'b1, 1'b1, lat, rd);
    chk("w7_write_lat", lat, 10);

    // Random write-then-read pairs
    for (int i = 0; i < 500; i++) begin
      a = 32'h200 + (32'($urandom_range(0, 15)) << 2) + ($urandom & 32'hFFC0_0000);
      s = 4'($urandom_range(1, 15));
      xfer("rnd_wr", 1'b1, 1'b1, a, s, $urandom, 4, ~s);
      xfer("rnd_rd", 1'($urandom_range(0, 1)), 1'b0, a, 4'h0, 32'h0, 3, 4'h0);
    end

    // Reset during the write pulse aborts the access with no ack
    b1.mem_req_i = 1'b1; b1.mem_we_i = 1'b1; b1.mem_addr_i = 32'h300; b1.mem_sel_i = 4'hF; b1.mem_data_i = 32'hBADC0FFE;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!we1) begin got = 1'b1; break; end
    end
    chk("rstw_reached_pulse", 32'(got), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstw_strobes", {29'd0, ce1, oe1, we1}, 32'd7);
    chk("rstw_be_addr", {8'd0, be1, a1}, {8'd0, 4'hF, 20'd0});
    b1.mem_req_i = 1'b0;
    got = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (b1.mem_ack_o || b1.if_ack_o) got = 1'b1;
    end
    chk("rstw_no_ack", 32'(got), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_mem_untouched", sram[32'h300 >> 2], shadow[32'h300 >> 2]);
    xfer("post_rst_rd", 1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 3, 4'h0);

    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
